// File: rtl/updown_step_counter.sv
// Registered up/down counter with programmable step, load and wrap/saturate.
// Optional sticky overflow flag under COUNTER_OVF_STICKY_EN.
module updown_step_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_sat,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_ovf_clr,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_ovf,
  output logic              o_zero,
  output logic              o_tc,
  output logic              o_ovf_sticky
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             carry;

  assign step_x = {{(WIDTH+1-STEP_W){1'b0}}, i_step};
  assign sum    = {1'b0, count_q} + step_x;
  assign diff   = {1'b0, count_q} - step_x;
  // Bit WIDTH is the carry going up and the borrow going down.
  assign carry  = i_dir ? sum[WIDTH] : diff[WIDTH];

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_en) begin
      ovf_d = carry;
      if (carry && i_sat) begin
        count_d = i_dir ? '1 : '0;
      end else begin
        count_d = i_dir ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= RESET_VAL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (i_ovf_clr) sticky_d = 1'b0;
    if (ovf_d)     sticky_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign o_ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = i_ovf_clr;
  assign o_ovf_sticky   = 1'b0;
`endif

  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_zero  = (count_q == '0);
  assign o_tc    = i_dir ? (&count_q) : (count_q == '0);

endmodule

// File: tb/tb_updown_step_counter.sv
// Directed bench for updown_step_counter with an arithmetic reference model.
// Also builds with COUNTER_OVF_STICKY_EN defined.
module tb_updown_step_counter;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int MOD = 1 << W;
`ifdef COUNTER_OVF_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, dir, sat, load, clr;
  logic [SW-1:0] step;
  logic [W-1:0]  lval;
  logic [W-1:0]  count;
  logic          ovf, zero, tc, sticky;

  int tests = 0;
  int fails = 0;

  int m_count;
  bit m_ovf;
  bit m_sticky;

  updown_step_counter #(.WIDTH(W), .STEP_W(SW), .RESET_VAL('0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_dir        (dir),
    .i_step       (step),
    .i_sat        (sat),
    .i_load       (load),
    .i_load_val   (lval),
    .i_ovf_clr    (clr),
    .o_count      (count),
    .o_ovf        (ovf),
    .o_zero       (zero),
    .o_tc         (tc),
    .o_ovf_sticky (sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented rules.
  always @(posedge clk or negedge rst_n) begin
    int r;
    bit o;
    if (!rst_n) begin
      m_count  <= 0;
      m_ovf    <= 1'b0;
      m_sticky <= 1'b0;
    end else if (load) begin
      m_count <= int'(lval);
      m_ovf   <= 1'b0;
      if (clr) m_sticky <= 1'b0;
    end else if (en) begin
      r = dir ? m_count + int'(step) : m_count - int'(step);
      o = (r >= MOD) || (r < 0);
      if (o && sat)  r = dir ? MOD - 1 : 0;
      else if (r < 0) r = r + MOD;
      else if (r >= MOD) r = r - MOD;
      m_count <= r;
      m_ovf   <= o;
      if (o && STK) m_sticky <= 1'b1;
      else if (clr) m_sticky <= 1'b0;
    end else begin
      m_ovf <= 1'b0;
      if (clr) m_sticky <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_count", int'(count), m_count);
    chk("m_ovf", int'(ovf), int'(m_ovf));
    chk("m_zero", int'(zero), int'(m_count == 0));
    chk("m_tc", int'(tc), dir ? int'(m_count == MOD - 1) : int'(m_count == 0));
    chk("m_sticky", int'(sticky), int'(m_sticky));
  end

  task automatic cyc(input bit e, input bit d, input int s, input bit st,
                     input bit ld, input int lv, input bit c);
    en = e; dir = d; step = SW'(s); sat = st;
    load = ld; lval = W'(lv); clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, dir, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; dir = 1; step = '0; sat = 0; load = 0; lval = '0; clr = 0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_sticky", int'(sticky), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("up1", int'(count), 16'h0001);
    chk("up1_zero", int'(zero), 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("up2", int'(count), 16'h0002);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("up3", int'(count), 16'h0003);
    chk("up3_ovf", int'(ovf), 0);

    cyc(0, 1, 0, 0, 1, 16'hFFFE, 0);
    cyc(1, 1, 3, 0, 0, 0, 0);
    chk("wrap_up", int'(count), 16'h0001);
    chk("wrap_up_ovf", int'(ovf), 1);
    idle();
    chk("ovf_pulse", int'(ovf), 0);
    chk("ovf_hold", int'(count), 16'h0001);

    cyc(0, 1, 0, 0, 1, 16'hFFFE, 0);
    cyc(1, 1, 3, 1, 0, 0, 0);
    chk("sat_up", int'(count), 16'hFFFF);
    chk("sat_up_ovf", int'(ovf), 1);
    cyc(1, 1, 3, 1, 0, 0, 0);
    chk("sat_up2", int'(count), 16'hFFFF);
    chk("sat_up2_ovf", int'(ovf), 1);
    chk("tc_up", int'(tc), 1);

    cyc(0, 0, 0, 0, 1, 16'h0002, 0);
    cyc(1, 0, 5, 0, 0, 0, 0);
    chk("wrap_dn", int'(count), 16'hFFFD);
    chk("wrap_dn_ovf", int'(ovf), 1);
    cyc(0, 0, 0, 0, 1, 16'h0002, 0);
    cyc(1, 0, 5, 1, 0, 0, 0);
    chk("sat_dn", int'(count), 16'h0000);
    chk("sat_dn_ovf", int'(ovf), 1);
    chk("sat_dn_zero", int'(zero), 1);
    chk("sat_dn_tc", int'(tc), 1);

    cyc(1, 1, 7, 1, 1, 16'h1234, 0);
    chk("load_pri", int'(count), 16'h1234);
    chk("load_pri_ovf", int'(ovf), 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("step0", int'(count), 16'h1234);
    chk("step0_ovf", int'(ovf), 0);
    cyc(0, 0, 15, 1, 0, 0, 0);
    chk("en0_hold", int'(count), 16'h1234);
    cyc(1, 0, 4, 0, 0, 0, 0);
    chk("down4", int'(count), 16'h1230);

    cyc(0, 1, 0, 0, 1, 16'h009F, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("reach_a0", int'(count), 16'h00A0);
    load = 1; lval = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", int'(count), 0);
    load = 0;
    @(posedge clk);
    #1;
    chk("in_rst", int'(count), 0);
    rst_n = 1'b1;
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("post_rel", int'(count), 0);

    cyc(0, 1, 0, 0, 1, 16'hFFFF, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("stk_wrap", int'(count), 0);
    chk("stk_set", int'(sticky), int'(STK));
    idle();
    idle();
    chk("stk_persist", int'(sticky), int'(STK));
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("stk_clr", int'(sticky), 0);
    cyc(0, 1, 0, 0, 1, 16'hFFFF, 0);
    cyc(1, 1, 2, 0, 0, 0, 1);
    chk("stk_setwins", int'(sticky), int'(STK));
    chk("stk_setwins_cnt", int'(count), 16'h0001);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
